ct_butterfly: RTL

Pipelined Cooley-Tukey (decimation-in-time) radix-2 butterfly for the forward NTT, the counterpart of the Gentleman-Sande butterfly used in the inverse NTT. Computes a = (A + w*B) mod Q and b = (A - w*B) mod Q on 30-bit residues. Full throughput (one butterfly per clock), fixed latency, valid-tagged, no backpressure. Instantiated by the forward-NTT stage controller between coefficient memory read and write-back.

---
 rtl/ntt_pkg.sv | 16 +
 rtl/ct_butterfly_if.sv | 16 +
 rtl/mod_mul_barrett.sv | 55 +++++
 rtl/ct_butterfly.sv | 86 ++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT arithmetic constants for the forward (CT) and inverse (GS) butterflies.
// Both butterflies import this package so that they always agree on the modulus.
package ntt_pkg;

    localparam int unsigned CoefW = 30;
    localparam int unsigned ProdW = 60;
    localparam int unsigned Latency = 6;
    localparam int unsigned MulLatency = 4;

    typedef logic [CoefW-1:0] coef_t;

    localparam coef_t Q = 30'd1073479681;
    // Barrett constant floor(2^60 / Q); it fits in 31 bits because Q > 2^29.
    localparam logic [30:0] MU = 31'(64'h1000_0000_0000_0000 / 64'(Q));

endpackage

// File: rtl/ct_butterfly_if.sv
// Sample bus of the CT butterfly: operands in, valid-tagged results out, no backpressure.
interface ct_butterfly_if;
    import ntt_pkg::*;

    logic  valid_i;
    coef_t A;
    coef_t B;
    coef_t w;
    logic  valid_o;
    coef_t a;
    coef_t b;

    modport master (output valid_i, A, B, w, input valid_o, a, b);
    modport slave  (input valid_i, A, B, w, output valid_o, a, b);

endinterface

// File: rtl/mod_mul_barrett.sv
// Pipelined 30x30-bit modular multiplier with Barrett reduction, 4 cycles from x_i/y_i to z_o.
// The valid tag travels alongside the data; data registers update every cycle.
module mod_mul_barrett
    import ntt_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  valid_i,
    input  coef_t x_i,
    input  coef_t y_i,
    output logic  valid_o,
    output coef_t z_o
);

    logic [MulLatency-1:0] vld_q, vld_d;
    logic [ProdW-1:0]      p_q, p_d;
    logic [31:0]           plo_q, plo_d;
    logic [61:0]           q2_q, q2_d;
    logic [31:0]           r_q, r_d;
    logic [31:0]           r1;
    coef_t                 t_q, t_d;

    always_comb begin
        vld_d = {vld_q[MulLatency-2:0], valid_i};
        p_d   = ProdW'(x_i) * ProdW'(y_i);
        q2_d  = 62'(31'(p_q >> 29)) * 62'(MU);
        plo_d = 32'(p_q);
        // Only the low 32 bits matter: the true remainder is below 3Q < 2^32.
        r_d   = plo_q - 32'(q2_q >> 31) * 32'(Q);
        r1    = (r_q >= 32'(Q)) ? r_q - 32'(Q) : r_q;
        t_d   = (r1 >= 32'(Q)) ? CoefW'(r1 - 32'(Q)) : CoefW'(r1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            p_q   <= '0;
            plo_q <= '0;
            q2_q  <= '0;
            r_q   <= '0;
            t_q   <= '0;
        end else begin
            vld_q <= vld_d;
            p_q   <= p_d;
            plo_q <= plo_d;
            q2_q  <= q2_d;
            r_q   <= r_d;
            t_q   <= t_d;
        end
    end

    assign valid_o = vld_q[MulLatency-1];
    assign z_o     = t_q;

endmodule

// File: rtl/ct_butterfly.sv
// Forward-NTT Cooley-Tukey butterfly: a = A + w*B, b = A - w*B (mod Q), fixed 6-cycle latency.
// Stage 1 registers the inputs, stages 2-5 are the modular multiplier, stage 6 the add/sub.
module ct_butterfly
    import ntt_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ct_butterfly_if.slave bus
);

    logic       v1_q, v1_d;
    coef_t      a1_q, a1_d;
    coef_t      b1_q, b1_d;
    coef_t      w1_q, w1_d;
    coef_t      a_dly_q [MulLatency];
    coef_t      a_dly_d [MulLatency];
    logic       mm_valid;
    coef_t      mm_t;
    coef_t      a6;
    logic [CoefW:0] sum;
    logic       vo_q, vo_d;
    coef_t      ao_q, ao_d;
    coef_t      bo_q, bo_d;

    mod_mul_barrett u_mul (
        .clk     (clk),
        .rst     (rst),
        .valid_i (v1_q),
        .x_i     (b1_q),
        .y_i     (w1_q),
        .valid_o (mm_valid),
        .z_o     (mm_t)
    );

    always_comb begin
        v1_d = bus.valid_i;
        a1_d = bus.A;
        b1_d = bus.B;
        w1_d = bus.w;
        // A rides beside the multiplier so it meets t in the final stage.
        a_dly_d[0] = a1_q;
        for (int i = 1; i < MulLatency; i++) begin
            a_dly_d[i] = a_dly_q[i-1];
        end
        a6   = a_dly_q[MulLatency-1];
        sum  = {1'b0, a6} + {1'b0, mm_t};
        vo_d = mm_valid;
        ao_d = (sum >= {1'b0, Q}) ? CoefW'(sum - {1'b0, Q}) : CoefW'(sum);
        bo_d = (a6 < mm_t) ? a6 - mm_t + Q : a6 - mm_t;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            a1_q <= '0;
            b1_q <= '0;
            w1_q <= '0;
            for (int i = 0; i < MulLatency; i++) begin
                a_dly_q[i] <= '0;
            end
            vo_q <= 1'b0;
            ao_q <= '0;
            bo_q <= '0;
        end else begin
            v1_q <= v1_d;
            a1_q <= a1_d;
            b1_q <= b1_d;
            w1_q <= w1_d;
            for (int i = 0; i < MulLatency; i++) begin
                a_dly_q[i] <= a_dly_d[i];
            end
            vo_q <= vo_d;
            ao_q <= ao_d;
            bo_q <= bo_d;
        end
    end

    assign bus.valid_o = vo_q;
    assign bus.a       = ao_q;
    assign bus.b       = bo_q;

    // Operands at or above Q have no defined result.
    operand_range_a: assert property (@(posedge clk) disable iff (rst)
        bus.valid_i |-> (bus.A < Q && bus.B < Q && bus.w < Q));

endmodule
